// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array front end: sequencer states,
// default array geometry and the beat/flush counter width helper.
package sa_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM,
    FLUSH
  } state_t;

  localparam int BIT_WIDTH = 8;
  localparam int ROWS      = 4;
  localparam int COLS      = 4;

  // Wide enough to hold a count of 0..n inclusive.
  function automatic int cntWidth(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sa_input_sequencer_skew_line.sv
// Fixed-depth shift register used to delay one activation lane
// ({valid, data}) by its row's diagonal skew.
module skew_line #(
  parameter int depth = 1,
  parameter int width = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [width-1:0] i_d,
  output logic [width-1:0] o_q
);

  logic [width-1:0] r_stage [depth];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < depth; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < depth; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[depth-1];

endmodule

// File: rtl/sa_input_sequencer.sv
// Host-side feeder for a weight-stationary systolic array: shifts one weight
// tile down the columns, then streams skewed activation vectors into the rows.
module sa_input_sequencer
  import sa_pkg::*;
#(
  parameter int bit_width = BIT_WIDTH,
  parameter int rows      = ROWS,
  parameter int cols      = COLS
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  input  logic                      i_wt_valid,
  output logic                      o_wt_ready,
  input  logic [cols*bit_width-1:0] i_wt_data,
  input  logic                      i_act_valid,
  output logic                      o_act_ready,
  input  logic [rows*bit_width-1:0] i_act_data,
  input  logic                      i_act_last,
  output logic                      o_control,
  output logic [cols*bit_width-1:0] o_wt_col_out,
  output logic [rows*bit_width-1:0] o_data_row_out,
  output logic [rows-1:0]           o_data_row_vld,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam int CW = cntWidth(rows);
  localparam logic [CW-1:0] LOAD_LAST  = CW'(rows - 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'((rows > 1) ? rows - 2 : 0);

  state_t                    r_state;
  state_t                    w_next;
  logic [CW-1:0]             r_count;
  logic                      r_done;
  logic                      r_control;
  logic [cols*bit_width-1:0] r_wtCol;
  logic                      w_wtAccept;
  logic                      w_actAccept;
  logic [rows*bit_width-1:0] w_injData;
  logic [bit_width:0]        w_laneQ [rows];

  assign w_wtAccept  = (r_state == LOAD)   && i_wt_valid;
  assign w_actAccept = (r_state == STREAM) && i_act_valid;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = LOAD;
      LOAD:    if (w_wtAccept && (r_count == LOAD_LAST)) w_next = STREAM;
      STREAM:  if (w_actAccept && i_act_last) w_next = (rows > 1) ? FLUSH : IDLE;
      FLUSH:   if (r_count == FLUSH_LAST) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // One counter serves both phases: it restarts on every state change.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_count <= '0;
      else if (w_wtAccept || (r_state == FLUSH)) r_count <= r_count + CW'(1);
      r_done <= ((r_state == STREAM) || (r_state == FLUSH)) && (w_next == IDLE);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_control <= 1'b0;
      r_wtCol   <= '0;
    end else begin
      r_control <= w_wtAccept;
      if (w_wtAccept) r_wtCol <= i_wt_data;
    end
  end

  assign w_injData = w_actAccept ? i_act_data : '0;

  // Lane r sits r+1 registers from acceptance, giving the diagonal wavefront.
  for (genvar g = 0; g < rows; g++) begin : g_lane
    skew_line #(
      .depth(g + 1),
      .width(bit_width + 1)
    ) u_skew (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_d    ({w_actAccept, w_injData[g*bit_width +: bit_width]}),
      .o_q    (w_laneQ[g])
    );
    assign o_data_row_out[g*bit_width +: bit_width] = w_laneQ[g][bit_width-1:0];
    assign o_data_row_vld[g]                        = w_laneQ[g][bit_width];
  end

  assign o_wt_ready   = (r_state == LOAD);
  assign o_act_ready  = (r_state == STREAM);
  assign o_busy       = (r_state != IDLE);
  assign o_done       = r_done;
  assign o_control    = r_control;
  assign o_wt_col_out = r_wtCol;

endmodule

// File: tb/tb_sa_input_sequencer.sv
// Randomized plus directed bench for sa_input_sequencer, checked against a
// time-indexed scoreboard of expected lane outputs and tile progress counters.
module tb_sa_input_sequencer;

  localparam int BW   = 8;
  localparam int ROWS = 4;
  localparam int COLS = 4;

  logic                 clk = 1'b0;
  logic                 rstN;
  logic                 start, wtValid, actValid, actLast;
  logic [COLS*BW-1:0]   wtData;
  logic [ROWS*BW-1:0]   actData;
  logic                 wtReady, actReady, control, busy, done;
  logic [COLS*BW-1:0]   wtCol;
  logic [ROWS*BW-1:0]   dataRow;
  logic [ROWS-1:0]      dataVld;

  int checks = 0;
  int passes = 0;

  // Scoreboard: beats still to load, streaming flag, flush cycles left,
  // and a time-indexed table of what each lane must show on each cycle.
  int            loadLeft, flushLeft, cyc, ctrlSeen;
  bit            streaming, expControl, expDone;
  logic [31:0]   expWtCol;
  logic [BW:0]   sched [ROWS][16];

  always #5 clk = ~clk;

  sa_input_sequencer #(.bit_width(BW), .rows(ROWS), .cols(COLS)) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_start(start),
    .i_wt_valid(wtValid), .o_wt_ready(wtReady), .i_wt_data(wtData),
    .i_act_valid(actValid), .o_act_ready(actReady), .i_act_data(actData),
    .i_act_last(actLast), .o_control(control), .o_wt_col_out(wtCol),
    .o_data_row_out(dataRow), .o_data_row_vld(dataVld),
    .o_busy(busy), .o_done(done)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit modelIdle();
    return (loadLeft == 0) && !streaming && (flushLeft == 0);
  endfunction

  task automatic modelReset();
    loadLeft = 0; flushLeft = 0; streaming = 0;
    expControl = 0; expDone = 0; expWtCol = '0; ctrlSeen = 0;
    for (int r = 0; r < ROWS; r++)
      for (int s = 0; s < 16; s++) sched[r][s] = '0;
  endtask

  task automatic runCycle();
    bit accAct;
    @(posedge clk);
    cyc++;
    expControl = 0; expDone = 0; accAct = 0;
    if (modelIdle()) begin
      if (start) begin loadLeft = ROWS; ctrlSeen = 0; end
    end else if (loadLeft > 0) begin
      if (wtValid) begin
        expControl = 1; expWtCol = wtData; loadLeft--;
        if (loadLeft == 0) streaming = 1;
      end
    end else if (streaming) begin
      if (actValid) begin
        accAct = 1;
        if (actLast) begin
          streaming = 0;
          if (ROWS > 1) flushLeft = ROWS - 1; else expDone = 1;
        end
      end
    end else begin
      flushLeft--;
      if (flushLeft == 0) expDone = 1;
    end
    for (int r = 0; r < ROWS; r++)
      sched[r][(cyc + r) % 16] = accAct ? {1'b1, actData[r*BW +: BW]} : '0;
    #1;
    checkOutput("wtReady", wtReady, loadLeft > 0);
    checkOutput("actReady", actReady, streaming);
    checkOutput("busy", busy, !modelIdle());
    checkOutput("done", done, expDone);
    checkOutput("control", control, expControl);
    checkOutput("wtCol", wtCol, expWtCol);
    for (int r = 0; r < ROWS; r++)
      checkOutput($sformatf("lane%0d", r), {dataVld[r], dataRow[r*BW +: BW]}, sched[r][cyc % 16]);
    if (control) ctrlSeen++;
    if (expDone) checkOutput("ctrlPulses", ctrlSeen, ROWS);
  endtask

  task automatic applyStimulus(input bit s, input bit wv, input logic [31:0] wd,
                               input bit av, input logic [31:0] ad, input bit al);
    start = s; wtValid = wv; wtData = wd; actValid = av; actData = ad; actLast = al;
    runCycle();
  endtask

  task automatic idleUntilDone();
    for (int i = 0; i < 12 && !expDone; i++) applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rstN = 1'b0; cyc = 0;
    start = 0; wtValid = 0; wtData = '0; actValid = 0; actData = '0; actLast = 0;
    modelReset();
    #12;
    checkOutput("resetA", {control, wtCol, dataRow}, '0);
    checkOutput("resetB", {dataVld, wtReady, actReady, busy, done}, '0);
    rstN = 1'b1;

    // Back-to-back load, three activation vectors, start again in the done cycle.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'h11111111, 0, 0, 0);
    applyStimulus(0, 1, 32'h22222222, 0, 0, 0);
    applyStimulus(0, 1, 32'h33333333, 0, 0, 0);
    applyStimulus(0, 1, 32'h44444444, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 32'h04030201, 0);
    applyStimulus(0, 0, 0, 1, 32'h08070605, 0);
    applyStimulus(0, 0, 0, 1, 32'h0C0B0A09, 1);
    idleUntilDone();
    applyStimulus(1, 0, 0, 0, 0, 0);

    // Gapped weight beats, gapped activations, start ignored while streaming.
    for (int i = 0; i < 8; i++) applyStimulus(0, (i % 2) == 0, 32'hA0A0A0A0 + i, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 32'h14131211, 0);
    applyStimulus(0, 0, 0, 0, 32'hFFFFFFFF, 1);
    applyStimulus(1, 0, 0, 1, 32'h24232221, 0);
    applyStimulus(0, 0, 0, 1, 32'h34333231, 1);
    idleUntilDone();
    applyStimulus(0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0, $urandom,
                    $urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 3) == 0);
    for (int i = 0; i < 40 && !modelIdle(); i++)
      applyStimulus(0, 1, $urandom, 1, $urandom, 1);

    // Reset while flushing: everything clears at once and no done follows.
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < ROWS; i++) applyStimulus(0, 1, $urandom, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 32'h55667788, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("inFlush", flushLeft > 0, 1);
    #2 rstN = 1'b0;
    #1;
    checkOutput("midResetA", {control, wtCol, dataRow}, '0);
    checkOutput("midResetB", {dataVld, wtReady, actReady, busy, done}, '0);
    modelReset();
    repeat (2) @(posedge clk);
    #3 rstN = 1'b1;
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sa_input_sequencer.md
# sa_input_sequencer

Feeds a weight-stationary systolic array of MAC processing elements from the host side. Loads one weight tile into the array by shifting row vectors down the weight path with the load control asserted, then streams activation vectors into the array's left edge with the per-row diagonal skew the array requires. It sits between the host buffers (valid/ready streams) and the top and left edges of the PE grid, driving every PE input that the array does not generate internally.

## Interface
- bit_width, 8, activation/weight element width (matches PE)
- rows, 4, PE rows (activation lanes, weight beats per tile)
- cols, 4, PE columns (weight lanes)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse begins a tile; ignored unless IDLE
- wt_valid / wt_ready  in / out  1 / 1  weight beat handshake
- wt_data  in  cols*bit_width  one weight row vector; lane c = bits [c*bit_width +: bit_width]
- act_valid / act_ready  in / out  1 / 1  activation beat handshake
- act_data  in  rows*bit_width  one activation vector; lane r feeds array row r
- act_last  in  1  marks final activation beat of the tile
- control  out  1  weight-load enable broadcast to all PEs
- wt_col_out  out  cols*bit_width  to top-row PE weight inputs
- data_row_out  out  rows*bit_width  to left-column PE data inputs, skewed
- data_row_vld  out  rows  per-row valid tag, skewed identically (for drain side)
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at tile completion

## Operation
- FSM states: IDLE, LOAD, STREAM, FLUSH.
- IDLE: all readies 0. start -> LOAD, beat counter cleared.
- LOAD: wt_ready=1. Each accepted beat (wt_valid & wt_ready) increments counter; rows-th accepted beat -> STREAM. Host sends bottom PE row's weights first (first beat shifts furthest).
- control and wt_col_out are registered: cycle after an accepted beat, control=1 and wt_col_out=that beat; cycle after a non-accept, control=0, wt_col_out holds. Exactly rows control pulses per tile regardless of wt_valid gaps.
- STREAM: act_ready=1. Accepted beat enters skew stage with valid=1; non-accept cycle injects zero vector with valid=0. Accepted beat with act_last -> FLUSH (or IDLE with done if rows==1).
- FLUSH: act_ready=0; zeros/valid=0 injected for rows-1 cycles, then -> IDLE with done.
- Skew: lane r delayed 1+r cycles from acceptance (lane 0 one register, lane r r extra).
- Outside STREAM/FLUSH injection is zero/valid=0; data already in the skew chain always drains.
- start outside IDLE ignored. wt_* ignored outside LOAD, act_* outside STREAM.
- Counter width $clog2(rows+1); no arithmetic on data, pure transport.

## Timing
- Reset (async, any state): state IDLE, control=0, wt_col_out=0, data_row_out=0, data_row_vld=0, wt_ready=0, act_ready=0, busy=0, done=0, skew chains cleared. Reset mid-LOAD leaves a partially loaded array; host must restart the tile.
- wt_ready/act_ready are state decodes (no combinational path from valid).
- start at edge T -> LOAD from T+1; minimum load is rows cycles.
- Last beat accepted at edge T -> FLUSH T+1..T+rows-1; done=1 and busy=0 during cycle T+rows, coincident with that beat's lane rows-1 output.
- Zero-cycle turnaround: start accepted in the done cycle.

## Structure
- Package sa_pkg: state enum, bit_width/rows/cols defaults shared with the PE array top, counter width function.
- Sub-module skew_line (parameter depth, width): shift register with reset, instantiated per lane with depth r+1 carrying {valid, data}.

## Test plan
(rows=cols=4, bit_width=8)
- Back-to-back load of 0x11.., 0x22.., 0x33.., 0x44.. -> control high exactly 4 consecutive cycles, wt_col_out in same order, then act_ready=1.
- wt_valid toggled 1,0,1,0,... -> control pulses only in cycles after accepts, exactly 4 total, wt_col_out holds on gaps.
- Vectors [1,2,3,4],[5,6,7,8],[9,10,11,12] (last) accepted at T..T+2 -> lane0 outputs 1,5,9 at T+1..T+3; lane3 outputs 4,8,12 at T+4..T+6; vld matches; done at T+6.
- act_valid gap between beats -> zero with vld=0 inserted in every lane at its skewed position.
- start pulsed during STREAM -> no effect; second start in done cycle -> LOAD next cycle.
- reset dropped mid-FLUSH -> all outputs 0 immediately, IDLE, no done pulse after release.
